// File: rtl/dpc_pkg.sv
// Shared types and constants for the DPC window generator.
// Build option: define DPC_WIN_MIRROR_EN for mirrored borders (replicate otherwise).
package dpc_pkg;

    localparam int unsigned DPC_MAX_W     = 32;
    localparam int unsigned DPC_MAX_DEPTH = 1024;
    localparam int unsigned DPC_CNT_W     = 10;
    localparam int unsigned DPC_NUM_SLOTS = 9;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StRun,
        StFlush
    } dpc_state_e;

    // Window slot of (row, col) inside the 3x3 neighbourhood; row 0 = top, slot 0 at LSBs.
    function automatic int unsigned dpc_slot(input int unsigned row, input int unsigned col);
        return 3 * row + col;
    endfunction

endpackage

// File: rtl/dpc_line_delay.sv
// One-row line delay: on each advance, writes the new pixel and returns the pixel written
// Depth advances earlier (registered read, read-before-write on the same address).
module dpc_line_delay
    import dpc_pkg::*;
#(
    parameter int unsigned Width = DPC_MAX_W,
    parameter int unsigned Depth = DPC_MAX_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv_i,
    input  logic [Width-1:0] din_i,
    output logic [Width-1:0] dout_o
);

    localparam int unsigned     PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);

    logic [Width-1:0] mem [Depth];
    logic [Width-1:0] dout_q;
    logic [PtrW-1:0]  ptr_q, ptr_d;

    // Circular pointer moves only on an advance.
    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = (ptr_q == PtrLast) ? '0 : ptr_q + PtrW'(1);
        end
    end

    // Pointer state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Block-RAM style storage; contents are never cleared.
    always_ff @(posedge clk) begin
        if (adv_i) begin
            mem[ptr_q] <= din_i;
            dout_q     <= mem[ptr_q];
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/dpc_window_gen.sv
// 3x3 neighbourhood generator for the DPC path. One window per input pixel, centred one row
// and one column behind the input, with synthesised borders.
// Build option: DPC_WIN_MIRROR_EN selects mirrored borders; replicate when undefined.
module dpc_window_gen
    import dpc_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 512
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic [WIDTH-1:0]               data_in,
    output logic                           in_ready,
    output logic                           win_valid,
    output logic [DPC_NUM_SLOTS*WIDTH-1:0] win,
    output logic [DPC_CNT_W-1:0]           cen_x,
    output logic [DPC_CNT_W-1:0]           cen_y,
    output logic                           frame_done
);

    localparam int unsigned   CW      = DPC_CNT_W;
    localparam int unsigned   AW      = DPC_CNT_W + 1;
    localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
    localparam logic [CW-1:0] RowLast = CW'(IMG_H - 1);
    localparam logic [AW-1:0] AuxLast = AW'(IMG_W);

    // Array row/column substituted for the missing neighbour at each border.
`ifdef DPC_WIN_MIRROR_EN
    localparam logic [1:0] SelTop = 2'd2, SelBot = 2'd0, SelLeft = 2'd2, SelRight = 2'd0;
`else
    localparam logic [1:0] SelTop = 2'd1, SelBot = 2'd1, SelLeft = 2'd1, SelRight = 2'd1;
`endif

    typedef logic [WIDTH-1:0] pix_t;

    dpc_state_e state_q, state_d;
    logic [AW-1:0] aux_q, aux_d;
    logic [CW-1:0] in_col_q, in_col_d, in_row_q, in_row_d;
    logic [CW-1:0] out_x_q, out_x_d, out_y_q, out_y_d;
    logic          s1_q, s1_d, e1_q, e1_d, s2_q, s2_d, e2_q, e2_d;
    logic [CW-1:0] x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
    pix_t          d1_q, d1_d, b2_q, b2_d, m2_q, m2_d;
    pix_t          arr_q [3][3];
    pix_t          arr_d [3][3];
    pix_t          rd1, rd2, pix_in;
    logic [1:0]    rsel [3];
    logic [1:0]    csel [3];
    logic          win_valid_q, win_valid_d, frame_done_q, frame_done_d;
    logic [DPC_NUM_SLOTS*WIDTH-1:0] win_q, win_d;
    logic [CW-1:0] cen_x_q, cen_x_d, cen_y_q, cen_y_d;
    logic          acc, strobe, emit, last_px;

    assign in_ready = (state_q != StFlush);
    assign acc      = in_valid && in_ready;
    assign strobe   = acc || (state_q == StFlush);
    assign emit     = strobe && ((state_q == StRun) || (state_q == StFlush));
    assign last_px  = (in_col_q == ColLast) && (in_row_q == RowLast);
    // Flush ticks push don't-care data; it only ever lands in border-substituted slots.
    assign pix_in   = acc ? data_in : '0;

    // Row taps: rd1 is one row back, rd2 two rows back (advanced a cycle later).
    dpc_line_delay #(.Width(WIDTH), .Depth(IMG_W)) u_ld1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .adv_i  (strobe),
        .din_i  (pix_in),
        .dout_o (rd1)
    );

    dpc_line_delay #(.Width(WIDTH), .Depth(IMG_W)) u_ld2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .adv_i  (s1_q),
        .din_i  (rd1),
        .dout_o (rd2)
    );

    // Frame FSM plus input and centre raster counters.
    always_comb begin
        state_d  = state_q;
        aux_d    = aux_q;
        in_col_d = in_col_q;
        in_row_d = in_row_q;
        out_x_d  = out_x_q;
        out_y_d  = out_y_q;
        if (acc) begin
            if (in_col_q == ColLast) begin
                in_col_d = '0;
                in_row_d = (in_row_q == RowLast) ? '0 : in_row_q + CW'(1);
            end else begin
                in_col_d = in_col_q + CW'(1);
            end
        end
        if (emit) begin
            if (out_x_q == ColLast) begin
                out_x_d = '0;
                out_y_d = (out_y_q == RowLast) ? '0 : out_y_q + CW'(1);
            end else begin
                out_x_d = out_x_q + CW'(1);
            end
        end
        unique case (state_q)
            StIdle: begin
                if (acc) begin
                    state_d = StFill;
                    aux_d   = AW'(1);
                end
            end
            StFill: begin
                if (acc) begin
                    if (aux_q == AuxLast) begin
                        state_d = StRun;
                        aux_d   = '0;
                    end else begin
                        aux_d = aux_q + AW'(1);
                    end
                end
            end
            StRun: begin
                if (acc && last_px) begin
                    state_d = StFlush;
                    aux_d   = '0;
                end
            end
            StFlush: begin
                if (aux_q == AuxLast) begin
                    state_d = StIdle;
                    aux_d   = '0;
                end else begin
                    aux_d = aux_q + AW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Two-stage strobe pipeline aligning the new pixel column with the RAM read latency.
    always_comb begin
        s1_d = strobe;
        e1_d = emit;
        x1_d = x1_q;
        y1_d = y1_q;
        d1_d = d1_q;
        s2_d = s1_q;
        e2_d = e1_q;
        x2_d = x2_q;
        y2_d = y2_q;
        b2_d = b2_q;
        m2_d = m2_q;
        if (strobe) begin
            x1_d = out_x_q;
            y1_d = out_y_q;
            d1_d = pix_in;
        end
        if (s1_q) begin
            x2_d = x1_q;
            y2_d = y1_q;
            b2_d = d1_q;
            m2_d = rd1;
        end
    end

    // 3x3 shift array and border mux; column 2 is newest, row 0 is top.
    always_comb begin
        arr_d        = arr_q;
        win_valid_d  = s2_q && e2_q;
        win_d        = win_q;
        cen_x_d      = cen_x_q;
        cen_y_d      = cen_y_q;
        frame_done_d = 1'b0;
        rsel         = '{2'd0, 2'd1, 2'd2};
        csel         = '{2'd0, 2'd1, 2'd2};
        if (s2_q) begin
            for (int r = 0; r < 3; r++) begin
                arr_d[r][0] = arr_q[r][1];
                arr_d[r][1] = arr_q[r][2];
            end
            arr_d[0][2] = rd2;
            arr_d[1][2] = m2_q;
            arr_d[2][2] = b2_q;
        end
        if (y2_q == '0)      rsel[0] = SelTop;
        if (y2_q == RowLast) rsel[2] = SelBot;
        if (x2_q == '0)      csel[0] = SelLeft;
        if (x2_q == ColLast) csel[2] = SelRight;
        if (win_valid_d) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_d[dpc_slot(i, j)*WIDTH +: WIDTH] = arr_d[rsel[i]][csel[j]];
                end
            end
            cen_x_d      = x2_q;
            cen_y_d      = y2_q;
            frame_done_d = (x2_q == ColLast) && (y2_q == RowLast);
        end
    end

    // State registers; line RAM contents are deliberately left out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            aux_q        <= '0;
            in_col_q     <= '0;
            in_row_q     <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            s1_q         <= 1'b0;
            e1_q         <= 1'b0;
            x1_q         <= '0;
            y1_q         <= '0;
            d1_q         <= '0;
            s2_q         <= 1'b0;
            e2_q         <= 1'b0;
            x2_q         <= '0;
            y2_q         <= '0;
            b2_q         <= '0;
            m2_q         <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    arr_q[r][c] <= '0;
                end
            end
            win_valid_q  <= 1'b0;
            win_q        <= '0;
            cen_x_q      <= '0;
            cen_y_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            aux_q        <= aux_d;
            in_col_q     <= in_col_d;
            in_row_q     <= in_row_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            s1_q         <= s1_d;
            e1_q         <= e1_d;
            x1_q         <= x1_d;
            y1_q         <= y1_d;
            d1_q         <= d1_d;
            s2_q         <= s2_d;
            e2_q         <= e2_d;
            x2_q         <= x2_d;
            y2_q         <= y2_d;
            b2_q         <= b2_d;
            m2_q         <= m2_d;
            arr_q        <= arr_d;
            win_valid_q  <= win_valid_d;
            win_q        <= win_d;
            cen_x_q      <= cen_x_d;
            cen_y_q      <= cen_y_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_valid  = win_valid_q;
    assign win        = win_q;
    assign cen_x      = cen_x_q;
    assign cen_y      = cen_y_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dpc_window_gen.sv
// Scoreboard bench for dpc_window_gen on a 4x3 image with pixel(r,c) = base + 10*r + c.
module tb_dpc_window_gen;

    localparam int W  = 16;
    localparam int IW = 4;
    localparam int IH = 3;
    localparam int WW = 9 * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  data_in;
    logic          in_ready;
    logic          win_valid;
    logic [WW-1:0] win;
    logic [9:0]    cen_x;
    logic [9:0]    cen_y;
    logic          frame_done;

    dpc_window_gen #(.WIDTH(W), .IMG_W(IW), .IMG_H(IH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .in_ready   (in_ready),
        .win_valid  (win_valid),
        .win        (win),
        .cen_x      (cen_x),
        .cen_y      (cen_y),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WW-1:0] win;
        logic [9:0]    x;
        logic [9:0]    y;
        logic          fd;
        int            base;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   fd_cnt  = 0;
    int   win_cnt = 0;

    // Hand-computed windows (slot 0 listed last so it lands at the LSBs).
    localparam logic [8:0][15:0] KAT11 =
        {16'd22, 16'd21, 16'd20, 16'd12, 16'd11, 16'd10, 16'd2, 16'd1, 16'd0};
`ifdef DPC_WIN_MIRROR_EN
    localparam logic [8:0][15:0] KAT00 =
        {16'd11, 16'd10, 16'd11, 16'd1, 16'd0, 16'd1, 16'd11, 16'd10, 16'd11};
    localparam logic [8:0][15:0] KAT23 =
        {16'd12, 16'd13, 16'd12, 16'd22, 16'd23, 16'd22, 16'd12, 16'd13, 16'd12};
`else
    localparam logic [8:0][15:0] KAT00 =
        {16'd11, 16'd10, 16'd10, 16'd1, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0};
    localparam logic [8:0][15:0] KAT23 =
        {16'd23, 16'd23, 16'd22, 16'd23, 16'd23, 16'd22, 16'd13, 16'd13, 16'd12};
`endif

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int ref_px(input int base, input int r, input int c);
        int rr = r;
        int cc = c;
`ifdef DPC_WIN_MIRROR_EN
        if (rr < 0) rr = -rr;
        if (rr > IH - 1) rr = 2 * (IH - 1) - rr;
        if (cc < 0) cc = -cc;
        if (cc > IW - 1) cc = 2 * (IW - 1) - cc;
`else
        if (rr < 0) rr = 0;
        if (rr > IH - 1) rr = IH - 1;
        if (cc < 0) cc = 0;
        if (cc > IW - 1) cc = IW - 1;
`endif
        return base + 10 * rr + cc;
    endfunction

    function automatic logic [WW-1:0] ref_win(input int base, input int r, input int c);
        logic [WW-1:0] w = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                w[(3 * (dr + 1) + (dc + 1)) * W +: W] = 16'(ref_px(base, r + dr, c + dc));
            end
        end
        return w;
    endfunction

    task automatic push_frame(input int base);
        exp_t e;
        for (int y = 0; y < IH; y++) begin
            for (int x = 0; x < IW; x++) begin
                e.win  = ref_win(base, y, x);
                e.x    = 10'(x);
                e.y    = 10'(y);
                e.fd   = (x == IW - 1) && (y == IH - 1);
                e.base = base;
                sb.push_back(e);
            end
        end
    endtask

    task automatic send_px(input int v, input int gap);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("ready_wait", 144'(in_ready), 144'd1);
        in_valid = 1'b1;
        data_in  = 16'(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int base, input int max_gap);
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                send_px(base + 10 * r + c, (max_gap > 0) ? int'($urandom_range(max_gap)) : 0);
            end
        end
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_pending", 144'(sb.size()), 144'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 144'(in_ready), 144'd1);
        chk({tag, "_win_valid"}, 144'(win_valid), 144'd0);
        chk({tag, "_win"}, win, '0);
        chk({tag, "_cen_x"}, 144'(cen_x), 144'd0);
        chk({tag, "_cen_y"}, 144'(cen_y), 144'd0);
        chk({tag, "_frame_done"}, 144'(frame_done), 144'd0);
    endtask

    // Monitor: pops the scoreboard whenever a window is presented.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (frame_done) fd_cnt++;
            if (frame_done && !win_valid) begin
                checks++;
                errors++;
                $display("FAIL frame_done_without_window cen=(%0d,%0d)", cen_y, cen_x);
            end
            if (win_valid) begin
                win_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_window actual cen=(%0d,%0d) required none", cen_y,
                             cen_x);
                end else begin
                    e = sb.pop_front();
                    chk("win", win, e.win);
                    chk("cen_x", 144'(cen_x), 144'(e.x));
                    chk("cen_y", 144'(cen_y), 144'(e.y));
                    chk("frame_done", 144'(frame_done), 144'(e.fd));
                    if (e.base == 0) begin
                        if (e.x == 10'd1 && e.y == 10'd1) chk("kat_1_1", win, KAT11);
                        if (e.x == 10'd0 && e.y == 10'd0) chk("kat_0_0", win, KAT00);
                        if (e.x == 10'd3 && e.y == 10'd2) chk("kat_2_3", win, KAT23);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        data_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Continuous frame with latency check, then flush with in_valid held high.
        push_frame(0);
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                int i = r * IW + c;
                send_px(10 * r + c, 0);
                if (i >= 5 && i <= 7)
                    chk("win_valid_latency", 144'(win_valid), (i == 7) ? 144'd1 : 144'd0);
            end
        end
        in_valid = 1'b1;
        data_in  = 16'd99;
        cnt      = 0;
        while (!in_ready && cnt < 20) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("flush_cycles", 144'(cnt), 144'd5);
        drain();

        // Random gaps on in_valid.
        push_frame(0);
        send_frame(0, 3);
        drain();

        // Abort after 6 pixels with a one-cycle reset, then a clean frame.
        for (int i = 0; i < 6; i++) send_px(10 * (i / IW) + (i % IW), 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_frame(0);
        send_frame(0, 0);
        drain();

        // Back-to-back frames, second offset by 100.
        push_frame(0);
        push_frame(100);
        send_frame(0, 0);
        send_frame(100, 0);
        drain();

        repeat (20) @(posedge clk);
        #1;
        chk("leftover_expected", 144'(sb.size()), 144'd0);
        chk("frame_done_count", 144'(fd_cnt), 144'd5);
        chk("window_count", 144'(win_cnt), 144'd60);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
